// File: rtl/xsdb_multi_slave_bridge.sv
// XSDB slave bridge: shared info/status region plus fan-out to C_NUM_CH DRP-style
// channels, with a per-access response watchdog and sticky error status.
module xsdb_multi_slave_bridge #(
   parameter int C_ADDR_WIDTH  = 17,
   parameter int C_DATA_WIDTH  = 16,
   parameter int C_NUM_CH      = 4,
   parameter int C_TIMEOUT     = 255,
   parameter int C_PIPE_IN     = 1,
   parameter int C_SLAVE_TYPE  = 1,
   parameter int C_CSE_DRV_VER = 1,
   parameter int C_NEXT_SLAVE  = 0,
   parameter logic [8*C_DATA_WIDTH-1:0] C_CORE_INFO = '0
) (
   input  logic                             s_dclk_i,
   input  logic                             s_rst_n_i,
   input  logic                             m_den_i,
   input  logic                             m_dwe_i,
   input  logic [C_ADDR_WIDTH-1:0]          m_daddr_i,
   input  logic [C_DATA_WIDTH-1:0]          m_di_i,
   output logic [C_DATA_WIDTH-1:0]          m_do_o,
   output logic                             m_drdy_o,
   output logic [C_NUM_CH-1:0]              ch_den_o,
   output logic                             ch_dwe_o,
   output logic [C_ADDR_WIDTH-1:0]          ch_daddr_o,
   output logic [C_DATA_WIDTH-1:0]          ch_di_o,
   input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] ch_do_i,
   input  logic [C_NUM_CH-1:0]              ch_drdy_i
);
   localparam int DW = C_DATA_WIDTH;
   localparam logic [DW-1:0] DEAD = DW'(16'hDEAD);
   localparam logic [15:0]   TO   = 16'(C_TIMEOUT);

   typedef struct packed {
      logic                    den;
      logic                    dwe;
      logic [C_ADDR_WIDTH-1:0] daddr;
      logic [DW-1:0]           di;
   } req_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   req_t req_in, req;
   assign req_in = {m_den_i, m_dwe_i, m_daddr_i, m_di_i};

   generate
      if (C_PIPE_IN != 0) begin : g_pipe
         req_t req_q;
         always_ff @(posedge s_dclk_i) begin
            if (!s_rst_n_i) req_q <= '0;
            else            req_q <= req_in;
         end
         assign req = req_q;
      end else begin : g_nopipe
         assign req = req_in;
      end
   endgenerate

   state_t              state_q, state_d;
   logic [7:0]          ofs;
   logic [2:0]          idx, ch_idx_q, st_last;
   logic                is_info, dec_err, drdy_hit;
   logic                acc, ovl_set, ch_done, ch_to, w1c;
   logic                st_ovl, st_dec, st_to;
   logic [C_NUM_CH-1:0] onehot, ch_sel_q;
   logic [DW-1:0]       test_q, info_rd, ch_rd;
   logic [15:0]         wd_q;

   assign ofs      = req.daddr[7:0];
   assign idx      = req.daddr[10:8];
   assign is_info  = &req.daddr[C_ADDR_WIDTH-1:8];
   assign dec_err  = !is_info && (32'(idx) >= C_NUM_CH);
   assign drdy_hit = |(ch_drdy_i & ch_sel_q);
   assign w1c      = acc && is_info && req.dwe && (ofs == 8'hF4);

   always_comb begin
      onehot = '0;
      for (int k = 0; k < C_NUM_CH; k++) onehot[k] = (32'(idx) == k);
   end

   always_comb begin
      ch_rd = '0;
      for (int k = 0; k < C_NUM_CH; k++)
         if (ch_sel_q[k]) ch_rd = ch_rd | ch_do_i[k*DW +: DW];
   end

   always_comb begin
      info_rd = DW'(C_SLAVE_TYPE);
      if (ofs < 8'h08) info_rd = C_CORE_INFO[32'(ofs[2:0])*DW +: DW];
      else begin
         case (ofs)
            8'hF1:   info_rd = DW'(C_CSE_DRV_VER);
            8'hF2:   info_rd = DW'(C_NUM_CH);
            8'hF3:   info_rd = DW'(TO);
            8'hF4:   info_rd = DW'({st_ovl, st_dec, st_to, st_last});
            8'hF6:   info_rd = test_q;
            8'hF7:   info_rd = DW'(C_NEXT_SLAVE);
            default: info_rd = DW'(C_SLAVE_TYPE);
         endcase
      end
   end

   always_ff @(posedge s_dclk_i) begin
      if (!s_rst_n_i) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // Watchdog value 0 marks the ch_den_o cycle, whose drdy is not honoured.
   always_comb begin
      state_d = state_q;
      acc     = 1'b0;
      ovl_set = 1'b0;
      ch_done = 1'b0;
      ch_to   = 1'b0;
      case (state_q)
         S_IDLE: if (req.den) begin
            acc     = 1'b1;
            state_d = (is_info || dec_err) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            ovl_set = req.den;
            if (wd_q != 16'd0 && drdy_hit) begin
               ch_done = 1'b1;
               state_d = S_RESP;
            end else if (wd_q == TO) begin
               ch_to   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            ovl_set = req.den;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge s_dclk_i) begin
      if (!s_rst_n_i) begin
         m_do_o     <= '0;
         m_drdy_o   <= 1'b0;
         ch_den_o   <= '0;
         ch_dwe_o   <= 1'b0;
         ch_daddr_o <= '0;
         ch_di_o    <= '0;
         ch_sel_q   <= '0;
         ch_idx_q   <= '0;
         wd_q       <= '0;
         test_q     <= '0;
         st_ovl     <= 1'b0;
         st_dec     <= 1'b0;
         st_to      <= 1'b0;
         st_last    <= '0;
      end else begin
         m_drdy_o <= 1'b0;
         ch_den_o <= '0;
         if (state_q == S_WAIT) wd_q <= wd_q + 16'd1;
         if (acc) begin
            wd_q <= '0;
            if (is_info) begin
               m_drdy_o <= 1'b1;
               m_do_o   <= info_rd;
               if (req.dwe && ofs == 8'hF6) test_q <= req.di;
            end else if (dec_err) begin
               m_drdy_o <= 1'b1;
               m_do_o   <= DEAD;
            end else begin
               ch_den_o   <= onehot;
               ch_sel_q   <= onehot;
               ch_idx_q   <= idx;
               ch_dwe_o   <= req.dwe;
               ch_daddr_o <= req.daddr;
               ch_di_o    <= req.di;
            end
         end
         if (ch_done) begin
            m_drdy_o <= 1'b1;
            m_do_o   <= ch_rd;
         end
         if (ch_to) begin
            m_drdy_o <= 1'b1;
            m_do_o   <= DEAD;
         end
         // Clears first so a same-cycle error set overrides them.
         if (w1c && req.di[5]) st_ovl <= 1'b0;
         if (w1c && req.di[4]) st_dec <= 1'b0;
         if (w1c && req.di[3]) begin
            st_to   <= 1'b0;
            st_last <= '0;
         end
         if (ovl_set)         st_ovl <= 1'b1;
         if (acc && dec_err)  st_dec <= 1'b1;
         if (ch_to) begin
            st_to   <= 1'b1;
            st_last <= ch_idx_q;
         end
      end
   end
endmodule
